// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: operand select codes, default widths,
// forwarding source and hazard FSM state types.
package pipe_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_REGBITS = 4;

    localparam logic [1:0] SEL1_PC   = 2'd0;
    localparam logic [1:0] SEL1_A    = 2'd1;
    localparam logic [1:0] SEL1_FWD  = 2'd2;
    localparam logic [1:0] SEL1_ZERO = 2'd3;

    localparam logic [1:0] SEL2_B    = 2'd0;
    localparam logic [1:0] SEL2_TWO  = 2'd1;
    localparam logic [1:0] SEL2_IMM  = 2'd2;
    localparam logic [1:0] SEL2_FWD  = 2'd3;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_E    = 2'd1,
        SRC_W    = 2'd2
    } src_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_match_component.sv
// Single-operand match: decides whether one source register is supplied
// from the EX/MEM shadow, the MEM/WB shadow, or the register file.
module fwd_match_component
    import pipe_pkg::*;
#(
    parameter int REGBITS = DEF_REGBITS
) (
    input  logic               candidate,
    input  logic [REGBITS-1:0] rs,
    input  logic [REGBITS-1:0] exm_rd,
    input  logic               exm_we,
    input  logic [REGBITS-1:0] mwb_rd,
    input  logic               mwb_we,
    output src_t               need
);

    logic hit_e;
    logic hit_w;

    // The younger EX/MEM result shadows an older MEM/WB write to the same register.
    always_comb begin
        hit_e = exm_we && (exm_rd == rs) && (rs != '0);
        hit_w = mwb_we && (mwb_rd == rs) && (rs != '0) && !hit_e;
        need  = SRC_NONE;
        if (candidate && hit_e) begin
            need = SRC_E;
        end else if (candidate && hit_w) begin
            need = SRC_W;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Hazard/forwarding controller: shadows EX/MEM and MEM/WB results, drives the
// execute operand selects and forwarding bus, and inserts one-cycle stalls.
module forward_hazard_unit
    import pipe_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REGBITS = DEF_REGBITS,
    parameter int CNTW    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REGBITS-1:0] ex_rs1,
    input  logic [REGBITS-1:0] ex_rs2,
    input  logic [REGBITS-1:0] ex_rd,
    input  logic               ex_regwrite,
    input  logic               ex_memread,
    input  logic [1:0]         ex_aluin1_base,
    input  logic [1:0]         ex_aluin2_base,
    input  logic [WIDTH-1:0]   aluout,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic [1:0]         aluin1,
    output logic [1:0]         aluin2,
    output logic [WIDTH-1:0]   forwarded_aluout,
    output logic               stall,
    output logic               kill_ex,
    output logic [CNTW-1:0]    stall_count
);

    state_t             state, state_next;
    logic [REGBITS-1:0] exm_rd, mwb_rd;
    logic               exm_we, exm_ld, mwb_we;
    logic [WIDTH-1:0]   exm_val, mwb_val;
    src_t               need1, need2;
    logic               cand1, cand2;
    logic               load_use, conflict;

    assign cand1 = (ex_aluin1_base == SEL1_A);
    assign cand2 = (ex_aluin2_base == SEL2_B);

    fwd_match_component #(.REGBITS(REGBITS)) u_match1 (
        .candidate (cand1),
        .rs        (ex_rs1),
        .exm_rd    (exm_rd),
        .exm_we    (exm_we),
        .mwb_rd    (mwb_rd),
        .mwb_we    (mwb_we),
        .need      (need1)
    );

    fwd_match_component #(.REGBITS(REGBITS)) u_match2 (
        .candidate (cand2),
        .rs        (ex_rs2),
        .exm_rd    (exm_rd),
        .exm_we    (exm_we),
        .mwb_rd    (mwb_rd),
        .mwb_we    (mwb_we),
        .need      (need2)
    );

    always_comb begin
        load_use = ((need1 == SRC_E) || (need2 == SRC_E)) && exm_ld;
        conflict = ((need1 == SRC_E) && (need2 == SRC_W)) ||
                   ((need1 == SRC_W) && (need2 == SRC_E));
    end

    always_comb begin
        state_next       = RUN;
        stall            = 1'b0;
        kill_ex          = 1'b0;
        aluin1           = ex_aluin1_base;
        aluin2           = ex_aluin2_base;
        forwarded_aluout = '0;
        // HOLD never stalls: kill_ex cleared the E shadow, so neither hazard can persist.
        if ((state == RUN) && (load_use || conflict)) begin
            stall      = 1'b1;
            kill_ex    = 1'b1;
            state_next = HOLD;
        end else begin
            if (need1 != SRC_NONE) aluin1 = SEL1_FWD;
            if (need2 != SRC_NONE) aluin2 = SEL2_FWD;
            if ((need1 == SRC_E) || (need2 == SRC_E)) begin
                forwarded_aluout = exm_val;
            end else if ((need1 == SRC_W) || (need2 == SRC_W)) begin
                forwarded_aluout = mwb_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            exm_rd      <= '0;
            exm_we      <= 1'b0;
            exm_ld      <= 1'b0;
            exm_val     <= '0;
            mwb_rd      <= '0;
            mwb_we      <= 1'b0;
            mwb_val     <= '0;
            stall_count <= '0;
        end else begin
            state   <= state_next;
            exm_rd  <= ex_rd;
            exm_we  <= ex_regwrite && !kill_ex;
            exm_ld  <= ex_memread && !kill_ex;
            exm_val <= aluout;
            mwb_rd  <= exm_rd;
            mwb_we  <= exm_we;
            mwb_val <= exm_ld ? mem_rdata : exm_val;
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule
